muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter MUL_PIPE, default 1, register stages after the combinational 128-bit product (legal 1..3).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 SHALL have port op  input  2  operation: 0=MUL, 1=DIV, 2=MOD, 3=reserved.
REQ-007 SHALL have port is_alu32  input  1  32-bit eBPF ALU class when high.
REQ-008 SHALL have port src_a  input  64  dividend or multiplicand (eBPF dst).
REQ-009 SHALL have port src_b  input  64  divisor or multiplier (eBPF src/imm).
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port result  output  64  operation result.
REQ-013 SHALL have port illegal  output  1  qualifies result; high for reserved op or a compiled-out operation.

Function
REQ-014 SHALL accept a request only when in_valid and in_ready are both high in the same cycle (cycle 0), capturing op, is_alu32, src_a and src_b.
REQ-015 SHALL, when is_alu32 is high, use only bits [31:0] of both operands and zero-extend the 32-bit result to 64 bits.
REQ-016 SHALL use an FSM with states IDLE, MUL, DIV, DONE; IDLE->MUL on MUL, IDLE->DIV on DIV/MOD with non-zero divisor, IDLE->DONE on divide-by-zero or illegal op.
REQ-017 SHALL compute MUL as the unsigned product of captured operands, returning bits [63:0], with out_valid asserted in cycle 1+MUL_PIPE.
REQ-018 SHALL compute DIV/MOD unsigned with a radix-2 restoring algorithm, one quotient bit per cycle: 64 iterations (32 when is_alu32), out_valid in cycle 65 (33).
REQ-019 SHALL, for divisor zero, return 0 for DIV and the (truncated) dividend for MOD, with out_valid in cycle 1.
REQ-020 SHALL, for op=3, return result 0 with illegal high, out_valid in cycle 1.
REQ-021 SHALL hold result, illegal and out_valid stable in DONE until out_valid and out_ready are both high, then return to IDLE in the next cycle.
REQ-022 SHALL not assert in_ready in the cycle the result is consumed (no same-cycle back-to-back issue); next request earliest one cycle later.
REQ-023 SHALL ignore in_valid, op and operand changes while not in IDLE.

Reset
REQ-024 SHALL, when rst is high at a clock edge, force IDLE, out_valid=0, result=0, illegal=0, in_ready=1 in the following cycle, abandoning any in-flight operation, including mid-division.
REQ-025 SHALL give rst priority over every handshake in the same cycle.

Configuration
REQ-026 SHALL compile the divider in only when macro MULDIV_DIV_EN is defined; without it, DIV and MOD behave as op=3 (result 0, illegal high, 1-cycle latency) and no divider logic is instantiated.

Structure
REQ-027 SHALL place the op encoding enum (MULDIV_MUL/DIV/MOD/RSV), the FSM state enum and the constant XLEN=64 in shared package muldiv_pkg.
REQ-028 SHALL implement the iterative divider as sub-module div_core_64 (start, is_alu32, dividend, divisor -> done, quotient, remainder), instantiated only under MULDIV_DIV_EN.

Verification
REQ-029 SHALL cover MUL 64-bit: a=0xFFFF_FFFF_FFFF_FFFF, b=2, MUL_PIPE=1 -> result 0xFFFF_FFFF_FFFF_FFFE, out_valid in cycle 2.
REQ-030 SHALL cover MUL alu32: a=0x1_0000_0003, b=0x1_8000_0000 -> result 0x0000_0000_8000_0000.
REQ-031 SHALL cover DIV/MOD 64-bit: a=100, b=7 -> DIV 14 and MOD 2, each out_valid in cycle 65.
REQ-032 SHALL cover divide-by-zero: a=0x1234_5678_9ABC_DEF0, b=0, is_alu32=1 -> DIV 0, MOD 0x9ABC_DEF0, out_valid in cycle 1.
REQ-033 SHALL cover backpressure and reset: out_ready low 5 cycles holds result stable; rst pulsed at iteration 20 of a DIV -> in_ready=1 and out_valid=0 next cycle, no stale result.
REQ-034 SHALL cover op=3, and DIV with MULDIV_DIV_EN undefined -> result 0, illegal=1, out_valid in cycle 1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and width for the sequential multiply/divide unit
package muldiv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    MULDIV_MUL = 2'd0,
    MULDIV_DIV = 2'd1,
    MULDIV_MOD = 2'd2,
    MULDIV_RSV = 2'd3
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/div_core_64.sv
// rtl/div_core_64.sv - radix-2 restoring unsigned divider, one quotient bit per cycle
// The first iteration runs on the start edge so a 64-bit divide reports done 64 cycles later.
module div_core_64
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_alu32,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic            active_q, active_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dsr_q, dsr_d;

  logic [XLEN-1:0] rem_in, quo_in, dsr_in, rem_step;
  logic [XLEN:0]   trial, diff;
  logic            ge;

  always_comb begin
    if (start) begin
      rem_in = '0;
      // In 32-bit mode the dividend is pre-shifted so its bit 31 is consumed first.
      quo_in = is_alu32 ? {dividend[31:0], 32'b0} : dividend;
      dsr_in = is_alu32 ? {32'b0, divisor[31:0]} : divisor;
    end else begin
      rem_in = rem_q;
      quo_in = quo_q;
      dsr_in = dsr_q;
    end
    trial    = {rem_in, quo_in[XLEN-1]};
    diff     = trial - {1'b0, dsr_in};
    ge       = ~diff[XLEN];
    rem_step = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];

    active_d = active_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = is_alu32 ? 7'd31 : 7'd63;
      rem_d    = rem_step;
      quo_d    = {quo_in[XLEN-2:0], ge};
      dsr_d    = dsr_in;
    end else if (active_q) begin
      if (cnt_q != 7'd0) begin
        cnt_d = cnt_q - 7'd1;
        rem_d = rem_step;
        quo_d = {quo_in[XLEN-2:0], ge};
      end else begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
    end
  end

  assign done      = active_q && (cnt_q == 7'd0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential eBPF MUL/DIV/MOD unit with valid/ready handshake
// Divider present only when MULDIV_DIV_EN is defined; otherwise DIV/MOD report illegal.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int MUL_PIPE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            is_alu32,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam logic [1:0] MUL_LAST = 2'(MUL_PIPE);

  muldiv_state_e   state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic            alu32_q, alu32_d;
  logic [1:0]      mul_cnt_q, mul_cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;

  logic            accept;
  muldiv_op_e      op_e;
  logic [XLEN-1:0] a_m, b_m, mul_prod, mul_tap;

  assign accept   = in_valid && in_ready_q;
  assign op_e     = muldiv_op_e'(op);
  assign a_m      = is_alu32 ? {32'b0, src_a[31:0]} : src_a;
  assign b_m      = is_alu32 ? {32'b0, src_b[31:0]} : src_b;
  // Only the low word of the full product is ever returned.
  assign mul_prod = a_q * b_q;

  generate
    if (MUL_PIPE > 1) begin : g_pipe
      logic [XLEN-1:0] pipe_q [MUL_PIPE-1];
      logic [XLEN-1:0] pipe_d [MUL_PIPE-1];
      always_comb begin
        pipe_d[0] = mul_prod;
        for (int i = 1; i < MUL_PIPE - 1; i++) pipe_d[i] = pipe_q[i-1];
      end
      always_ff @(posedge clk) pipe_q <= pipe_d;
      assign mul_tap = pipe_q[MUL_PIPE-2];
    end else begin : g_nopipe
      assign mul_tap = mul_prod;
    end
  endgenerate

`ifdef MULDIV_DIV_EN
  logic            is_mod_q, is_mod_d;
  logic            div_start, div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  div_core_64 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_alu32  (is_alu32),
    .dividend  (a_m),
    .divisor   (b_m),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) is_mod_q <= 1'b0;
    else     is_mod_q <= is_mod_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    alu32_d   = alu32_q;
    mul_cnt_d = mul_cnt_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef MULDIV_DIV_EN
    is_mod_d  = is_mod_q;
    div_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu32_d = is_alu32;
          a_d     = a_m;
          b_d     = b_m;
          case (op_e)
            MULDIV_MUL: begin
              state_d   = ST_MUL;
              mul_cnt_d = 2'd1;
            end
            MULDIV_DIV, MULDIV_MOD: begin
`ifdef MULDIV_DIV_EN
              if (b_m == '0) begin
                state_d   = ST_DONE;
                result_d  = (op_e == MULDIV_MOD) ? a_m : '0;
                illegal_d = 1'b0;
              end else begin
                state_d   = ST_DIV;
                div_start = 1'b1;
                is_mod_d  = (op_e == MULDIV_MOD);
              end
`else
              state_d   = ST_DONE;
              result_d  = '0;
              illegal_d = 1'b1;
`endif
            end
            default: begin
              state_d   = ST_DONE;
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mul_cnt_q == MUL_LAST) begin
          state_d   = ST_DONE;
          result_d  = alu32_q ? {32'b0, mul_tap[31:0]} : mul_tap;
          illegal_d = 1'b0;
        end else begin
          mul_cnt_d = mul_cnt_q + 2'd1;
        end
      end
      ST_DIV: begin
`ifdef MULDIV_DIV_EN
        if (div_done) begin
          state_d   = ST_DONE;
          result_d  = is_mod_q ? div_rem : div_quo;
          illegal_d = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      alu32_q     <= 1'b0;
      mul_cnt_q   <= '0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu32_q     <= alu32_d;
      mul_cnt_q   <= mul_cnt_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
// Expectations for DIV/MOD follow MULDIV_DIV_EN.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        is_alu32;
  logic [63:0] src_a;
  logic [63:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        illegal;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int DLAT64 = DIV_EN ? 65 : 1;
  localparam int DLAT32 = DIV_EN ? 33 : 1;
  localparam bit DILL   = !DIV_EN;

  int tests = 0;
  int fails = 0;

  muldiv_seq #(.MUL_PIPE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .is_alu32  (is_alu32),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic a32,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp_res, input logic exp_ill,
                     input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op       = o;
    is_alu32 = a32;
    src_a    = a;
    src_b    = b;
    @(posedge clk);
    #1;
    op       = ~o;
    is_alu32 = ~a32;
    src_a    = ~a;
    src_b    = 64'hDEAD_BEEF;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 300);
    in_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " illegal"}, 64'(illegal), 64'(exp_ill));
    repeat (hold) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, " hold_result"}, result, exp_res);
    end
    out_ready = 1'b1;
    check({tag, " in_ready_consume"}, 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " out_valid_after"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 2'd0;
    is_alu32  = 1'b0;
    src_a     = '0;
    src_b     = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", result, 64'd0);
    check("reset illegal", 64'(illegal), 64'd0);

    run("mul64", 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2, 0);
    run("mul32", 2'd0, 1'b1, 64'h1_0000_0003, 64'h1_8000_0000, 64'h0000_0000_8000_0000, 1'b0, 2, 0);
    run("mul_wrap_bp", 2'd0, 1'b0, 64'h8000_0000_0000_0001, 64'd3, 64'h8000_0000_0000_0003, 1'b0, 2, 5);
    run("div64", 2'd1, 1'b0, 64'd100, 64'd7, DIV_EN ? 64'd14 : 64'd0, DILL, DLAT64, 0);
    run("mod64_bp", 2'd2, 1'b0, 64'd100, 64'd7, DIV_EN ? 64'd2 : 64'd0, DILL, DLAT64, 5);
    run("div32", 2'd1, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'hABCD_0000_0000_0007,
        DIV_EN ? 64'd14 : 64'd0, DILL, DLAT32, 0);
    run("div_big", 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000,
        DIV_EN ? 64'hFFFF_FFFF : 64'd0, DILL, DLAT64, 0);
    run("mod_big", 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000,
        DIV_EN ? 64'hFFFF_FFFF : 64'd0, DILL, DLAT64, 0);
    run("div0_32", 2'd1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, DILL, 1, 0);
    run("mod0_32", 2'd2, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'd0,
        DIV_EN ? 64'h9ABC_DEF0 : 64'd0, DILL, 1, 0);
    run("mod0_64", 2'd2, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0,
        DIV_EN ? 64'h1234_5678_9ABC_DEF0 : 64'd0, DILL, 1, 0);
    run("rsv", 2'd3, 1'b0, 64'd5, 64'd7, 64'd0, 1'b1, 1, 0);

    // Reset in the middle of a long divide (or while holding a result without the divider).
    @(negedge clk);
    in_valid = 1'b1;
    op       = 2'd1;
    is_alu32 = 1'b0;
    src_a    = 64'd100;
    src_b    = 64'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst result", result, 64'd0);
    check("midrst illegal", 64'(illegal), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    out_ready = 1'b0;
    check("midrst no_stale", 64'(seen), 64'd0);

    run("mul_after_rst", 2'd0, 1'b0, 64'h1234_5678, 64'h10, 64'h1_2345_6780, 1'b0, 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
